// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte-substitution tables, engine state enum and byte index helpers
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } isb_state_e;

    // Element 0 sits at the most significant end, so TABLE[b] is the image of byte b.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // First bit of byte k in a [0:127] state vector.
    function automatic logic [6:0] byte_lsb(input logic [3:0] k);
        return {k, 3'b000};
    endfunction

    // Byte index of row r within column c.
    function automatic logic [3:0] col_byte(input logic [1:0] c, input logic [1:0] r);
        return {c, r};
    endfunction

endpackage

// File: rtl/inv_sub_byter_seq_if.sv
// rtl/inv_sub_byter_seq_if.sv - state-in / state-out handshake bundle of the InvSubBytes engine
interface inv_sub_byter_seq_if;
    logic [0:127] Isb_in;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] Isb_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output Isb_in, in_valid, out_ready,
        input  in_ready, Isb_out, out_valid, busy
    );

    modport slave (
        input  Isb_in, in_valid, out_ready,
        output in_ready, Isb_out, out_valid, busy
    );
endinterface

// File: rtl/inv_sub_byte.sv
// rtl/inv_sub_byte.sv - combinational single-byte inverse S-box lookup
module inv_sub_byte
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = INV_SBOX[din];
endmodule

// File: rtl/inv_sub_byter_seq.sv
// rtl/inv_sub_byter_seq.sv - iterative InvSubBytes engine, LANES bytes substituted per cycle
module inv_sub_byter_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_byter_seq_if.slave   bus
);
    localparam int NPASS = 16 / LANES;
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;

    isb_state_e    state_q, state_d;
    logic [PW-1:0] pass_cnt_q, pass_cnt_d;
    logic [0:127]  st_q, st_d;

    logic [7:0] lane_in   [LANES];
    logic [7:0] lane_out  [LANES];
    logic [3:0] lane_byte [LANES];

    // Lane l of pass p works on byte p*LANES+l, so the passes tile the state exactly once.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_byte[l] = 4'(LANES * int'(pass_cnt_q) + l);
        assign lane_in[l]   = st_q[byte_lsb(lane_byte[l]) +: 8];
        inv_sub_byte u_inv_sub_byte (
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        st_d       = st_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d       = bus.Isb_in;
                    pass_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    st_d[byte_lsb(lane_byte[l]) +: 8] = lane_out[l];
                end
                if (pass_cnt_q == PW'(NPASS - 1)) begin
                    pass_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pass_cnt_q <= '0;
            st_q       <= '0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            st_q       <= st_d;
        end
    end

    // Handshake outputs decode the state register only, keeping them free of input paths.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.Isb_out   = st_q;

endmodule

// File: tb/tb_inv_sub_byter_seq.sv
// tb/tb_inv_sub_byter_seq.sv - self-checking bench for inv_sub_byter_seq at LANES 4, 8 and 16
module tb_inv_sub_byter_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inv_sub_byter_seq_if if4 ();
    inv_sub_byter_seq_if if8 ();
    inv_sub_byter_seq_if if16 ();

    inv_sub_byter_seq #(.LANES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    inv_sub_byter_seq #(.LANES(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    inv_sub_byter_seq #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    typedef struct {
        logic [0:127] din;
        logic [0:127] dout;
    } vec_t;
    vec_t tv [4];

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        logic [7:0] r;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        r = b;
        s = b;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [0:127] model_inv(input logic [0:127] s);
        logic [0:127] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_tbl[s[8*k +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] model_fwd(input logic [0:127] s);
        logic [0:127] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = fwd_tbl[s[8*k +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Feed one state to all three engines and collect their results and latencies.
    task automatic run_all(input logic [0:127] d, input logic [0:127] exp, input bit full);
        int l4 = -1, l8 = -1, l16 = -1, bc = 0, cyc = 0;
        if4.Isb_in = d;  if8.Isb_in = d;  if16.Isb_in = d;
        if4.in_valid = 1'b1; if8.in_valid = 1'b1; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0; if8.in_valid = 1'b0; if16.in_valid = 1'b0;
        if (if4.busy) bc++;
        while (cyc < 20 && (l4 < 0 || l8 < 0 || l16 < 0)) begin
            @(posedge clk); #1;
            cyc++;
            if (if4.out_valid && l4 < 0)  l4 = cyc;
            if (if8.out_valid && l8 < 0)  l8 = cyc;
            if (if16.out_valid && l16 < 0) l16 = cyc;
            if (if4.busy) bc++;
        end
        chk("out_l4", if4.Isb_out, exp);
        chk("out_l8", if8.Isb_out, exp);
        chk("out_l16", if16.Isb_out, exp);
        if (full) begin
            chk_int("lat_l4", l4, 4);
            chk_int("lat_l8", l8, 2);
            chk_int("lat_l16", l16, 1);
            chk_int("busy_cycles_l4", bc, 4);
        end
        if4.out_ready = 1'b1; if8.out_ready = 1'b1; if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0; if8.out_ready = 1'b0; if16.out_ready = 1'b0;
    endtask

    task automatic start4(input logic [0:127] d);
        int t = 0;
        if4.Isb_in   = d;
        if4.in_valid = 1'b1;
        while (!if4.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic wait_ov4(output int lat);
        lat = 0;
        while (!if4.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic hs4();
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
    endtask

    initial begin
        logic [0:127] a, b, p;
        logic [0:127] bq [8];
        int lat, idx, oi, last;
        logic take;

        for (int i = 0; i < 256; i++) fwd_tbl[i] = sbox_f(8'(i));
        for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);

        tv[0].din = {16{8'h63}};
        tv[0].dout = '0;
        tv[1].din = 128'h7c00ed16_01637c00_ed160163_7c00ed16;
        tv[1].dout = 128'h015253ff_09000152_53ff0900_015253ff;
        tv[2].din = '0;
        tv[2].dout = {16{8'h52}};
        tv[3].din = {16{8'hff}};
        tv[3].dout = {16{8'h7d}};

        if4.Isb_in = '0;  if4.in_valid = 1'b0;  if4.out_ready = 1'b0;
        if8.Isb_in = '0;  if8.in_valid = 1'b0;  if8.out_ready = 1'b0;
        if16.Isb_in = '0; if16.in_valid = 1'b0; if16.out_ready = 1'b0;

        rst_n = 1'b0;
        #1;
        chk("rst_out", if4.Isb_out, '0);
        chk_int("rst_out_valid", int'(if4.out_valid), 0);
        chk_int("rst_in_ready", int'(if4.in_ready), 1);
        chk_int("rst_busy", int'(if4.busy), 0);
        chk_int("rst_in_ready_l16", int'(if16.in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_all(tv[i].din, tv[i].dout, 1'b1);

        // Round trip: forward-substituted random states must come back unchanged.
        for (int i = 0; i < 1000; i++) begin
            p = rand128();
            run_all(model_fwd(p), p, (i < 3));
        end

        // Back-pressure in DONE while in_valid toggles with fresh data.
        a = rand128();
        start4(a);
        wait_ov4(lat);
        chk_int("bp_lat", lat, 4);
        for (int c = 0; c < 20; c++) begin
            if4.in_valid = c[0];
            if4.Isb_in   = rand128();
            @(posedge clk); #1;
            chk("bp_hold_out", if4.Isb_out, model_inv(a));
            chk_int("bp_hold_valid", int'(if4.out_valid), 1);
            chk_int("bp_in_ready", int'(if4.in_ready), 0);
        end
        b = rand128();
        if4.Isb_in    = b;
        if4.in_valid  = 1'b1;
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
        chk_int("bp_not_taken_busy", int'(if4.busy), 0);
        chk_int("bp_idle_ready", int'(if4.in_ready), 1);
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        chk_int("bp_taken_busy", int'(if4.busy), 1);
        wait_ov4(lat);
        chk_int("bp_second_lat", lat, 4);
        chk("bp_second_out", if4.Isb_out, model_inv(b));
        hs4();

        // Reset two passes into BUSY discards the partial state.
        start4(rand128());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", if4.Isb_out, '0);
        chk_int("midrst_out_valid", int'(if4.out_valid), 0);
        chk_int("midrst_in_ready", int'(if4.in_ready), 1);
        chk_int("midrst_busy", int'(if4.busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk_int("midrst_no_pulse", int'(if4.out_valid), 0);
        end
        a = rand128();
        start4(a);
        wait_ov4(lat);
        chk_int("postrst_lat", lat, 4);
        chk("postrst_out", if4.Isb_out, model_inv(a));
        hs4();

        // Streaming with both handshakes tied high.
        for (int i = 0; i < 8; i++) bq[i] = rand128();
        idx = 0;
        oi = 0;
        last = -1;
        if4.Isb_in    = bq[0];
        if4.in_valid  = 1'b1;
        if4.out_ready = 1'b1;
        for (int c = 0; c < 44; c++) begin
            take = if4.in_ready;
            if (if4.out_valid && oi < 8) begin
                chk("b2b_out", if4.Isb_out, model_inv(bq[oi]));
                if (last >= 0) chk_int("b2b_gap", c - last, 6);
                last = c;
                oi++;
            end
            @(posedge clk); #1;
            if (take && idx < 7) begin
                idx++;
                if4.Isb_in = bq[idx];
            end
        end
        chk_int("b2b_count", oi, 7);
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
